// File: rtl/ldi_pkg.sv
// Shared definitions for the LDI receive word aligner.
//   LDI_WORD_W      : bits per deserialized LDI word (7)
//   LDI_CLK_PATTERN : clock-lane word once correctly aligned, MSB earliest
//   ldi_align_state_t : aligner FSM states
//   ldi_next_slip / ldi_sat_inc : slip advance with wrap, 8-bit saturating increment
package ldi_pkg;

  localparam int unsigned LDI_WORD_W      = 7;
  localparam logic [6:0]  LDI_CLK_PATTERN = 7'b1100011;
  localparam logic [2:0]  LDI_MAX_SLIP    = 3'd6;
  localparam logic [7:0]  LDI_SWEEP_LEN   = 8'd7;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } ldi_align_state_t;

  function automatic logic [2:0] ldi_next_slip(input logic [2:0] s);
    return (s == LDI_MAX_SLIP) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [7:0] ldi_sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/ldi_lane_rotator.sv
// One lane of the LDI word aligner: registers the previous word and selects a
// 7-bit window out of {prev, cur} according to the current slip.
//   clock, reset_n : pixel clock, async active-low reset
//   word_i         : raw lane word, MSB earliest
//   slip_i         : rotation 0..6; 0 passes the previous word unchanged
//   word_o         : rotated word (combinational from prev register and word_i)
module ldi_lane_rotator
  import ldi_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [LDI_WORD_W-1:0] word_i,
  input  logic [2:0]            slip_i,
  output logic [LDI_WORD_W-1:0] word_o
);

  logic [LDI_WORD_W-1:0]   prev_q;
  logic [2*LDI_WORD_W-1:0] window;
  logic [2*LDI_WORD_W-1:0] shifted;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev_q <= '0;
    else          prev_q <= word_i;
  end

  // Bit 13 of the window is the earliest bit; shifting left by slip puts
  // window[13-slip : 7-slip] into the top seven bits.
  always_comb begin
    window  = {prev_q, word_i};
    shifted = window << slip_i;
    word_o  = shifted[2*LDI_WORD_W-1:LDI_WORD_W];
  end

endmodule

// File: rtl/ldi_word_aligner.sv
// LDI receive word aligner. Searches the bit rotation at which the clock-lane
// word equals PATTERN, qualifies it over LOCK_COUNT consecutive matches, then
// applies the same rotation to all data lanes while monitoring for loss.
//   clock, reset_n   : pixel clock, async active-low reset
//   enable           : run; low forces SEARCH and clears counters/flags
//   clk_lane_word    : raw clock-lane word (MSB earliest)
//   data_lane_words  : raw data-lane words, lane k at [7k+6:7k]
//   aligned_data     : registered rotated data-lane words
//   aligned_valid    : registered, high while locked and enabled
//   locked           : lock status
//   slip             : current rotation 0..6
//   lock_lost        : one-cycle pulse when lock drops due to errors
//   sweep_fail       : sticky, a full 7-slip sweep found no match
module ldi_word_aligner
  import ldi_pkg::*;
#(
  parameter int unsigned           LANES      = 4,
  parameter logic [LDI_WORD_W-1:0] PATTERN    = LDI_CLK_PATTERN,
  parameter int unsigned           LOCK_COUNT = 16,
  parameter int unsigned           LOSS_COUNT = 4,
  parameter int unsigned           SETTLE     = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [LDI_WORD_W-1:0]       clk_lane_word,
  input  logic [LDI_WORD_W*LANES-1:0] data_lane_words,
  output logic [LDI_WORD_W*LANES-1:0] aligned_data,
  output logic                        aligned_valid,
  output logic                        locked,
  output logic [2:0]                  slip,
  output logic                        lock_lost,
  output logic                        sweep_fail
);

  localparam logic [7:0] LOCK_THR  = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_THR  = 8'(LOSS_COUNT);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  ldi_align_state_t state_q, state_d;
  logic [2:0] slip_q, slip_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] match_cnt_q, match_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] sweep_cnt_q, sweep_cnt_d;
  logic       sweep_fail_q, sweep_fail_d;
  logic       lock_lost_q, lock_lost_d;
  logic       locked_q, locked_d;
  logic       valid_q;
  logic [LDI_WORD_W*LANES-1:0] aligned_q, data_rot;
  logic [LDI_WORD_W-1:0]       clk_rot;
  logic       clk_match;
  logic       advance;
  logic [7:0] cnt_inc;

  ldi_lane_rotator u_clk_rot (
    .clock   (clock),
    .reset_n (reset_n),
    .word_i  (clk_lane_word),
    .slip_i  (slip_q),
    .word_o  (clk_rot)
  );

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ldi_lane_rotator u_data_rot (
      .clock   (clock),
      .reset_n (reset_n),
      .word_i  (data_lane_words[LDI_WORD_W*k +: LDI_WORD_W]),
      .slip_i  (slip_q),
      .word_o  (data_rot[LDI_WORD_W*k +: LDI_WORD_W])
    );
  end

  assign clk_match = (clk_rot == PATTERN);

  always_comb begin
    state_d      = state_q;
    slip_d       = slip_q;
    settle_d     = settle_q;
    match_cnt_d  = match_cnt_q;
    err_cnt_d    = err_cnt_q;
    sweep_cnt_d  = sweep_cnt_q;
    sweep_fail_d = sweep_fail_q;
    lock_lost_d  = 1'b0;
    advance      = 1'b0;
    cnt_inc      = '0;

    if (!enable) begin
      // Settle is held loaded so a re-enable starts with a fresh settle window.
      state_d      = SEARCH;
      settle_d     = SETTLE_LD;
      match_cnt_d  = '0;
      err_cnt_d    = '0;
      sweep_cnt_d  = '0;
      sweep_fail_d = 1'b0;
    end else if (settle_q != '0) begin
      settle_d = settle_q - 4'd1;
    end else begin
      case (state_q)
        SEARCH: begin
          if (clk_match) begin
            state_d     = VERIFY;
            match_cnt_d = 8'd1;
            sweep_cnt_d = '0;
          end else begin
            advance = 1'b1;
          end
        end
        VERIFY: begin
          if (clk_match) begin
            cnt_inc     = ldi_sat_inc(match_cnt_q);
            match_cnt_d = cnt_inc;
            sweep_cnt_d = '0;
            if (cnt_inc == LOCK_THR) begin
              state_d      = LOCKED;
              err_cnt_d    = '0;
              sweep_fail_d = 1'b0;
            end
          end else begin
            state_d     = SEARCH;
            match_cnt_d = '0;
            advance     = 1'b1;
          end
        end
        LOCKED: begin
          if (clk_match) begin
            err_cnt_d   = '0;
            sweep_cnt_d = '0;
          end else begin
            cnt_inc   = ldi_sat_inc(err_cnt_q);
            err_cnt_d = cnt_inc;
            if (cnt_inc == LOSS_THR) begin
              // Slip is kept: the search resumes at the rotation that was locked.
              state_d     = SEARCH;
              err_cnt_d   = '0;
              match_cnt_d = '0;
              settle_d    = SETTLE_LD;
              lock_lost_d = 1'b1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase

      if (advance) begin
        slip_d      = ldi_next_slip(slip_q);
        settle_d    = SETTLE_LD;
        sweep_cnt_d = ldi_sat_inc(sweep_cnt_q);
        if (sweep_cnt_d >= LDI_SWEEP_LEN) sweep_fail_d = 1'b1;
      end
    end
  end

  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SEARCH;
      slip_q       <= '0;
      settle_q     <= '0;
      match_cnt_q  <= '0;
      err_cnt_q    <= '0;
      sweep_cnt_q  <= '0;
      sweep_fail_q <= 1'b0;
      lock_lost_q  <= 1'b0;
      locked_q     <= 1'b0;
      valid_q      <= 1'b0;
      aligned_q    <= '0;
    end else begin
      state_q      <= state_d;
      slip_q       <= slip_d;
      settle_q     <= settle_d;
      match_cnt_q  <= match_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sweep_cnt_q  <= sweep_cnt_d;
      sweep_fail_q <= sweep_fail_d;
      lock_lost_q  <= lock_lost_d;
      locked_q     <= locked_d;
      valid_q      <= locked_d & enable;
      aligned_q    <= data_rot;
    end
  end

  assign aligned_data  = aligned_q;
  assign aligned_valid = valid_q;
  assign locked        = locked_q;
  assign slip          = slip_q;
  assign lock_lost     = lock_lost_q;
  assign sweep_fail    = sweep_fail_q;

endmodule

// File: tb/tb_ldi_word_aligner.sv
module tb_ldi_word_aligner;

  localparam int          LANES   = 4;
  localparam logic [6:0]  PAT     = 7'b1100011;
  localparam int          LOCKN   = 16;
  localparam int          LOSSN   = 4;
  localparam int          SETTLEN = 2;
  localparam int          DW      = 7 * LANES;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [6:0]    clk_lane_word = '0;
  logic [DW-1:0] data_lane_words = '0;
  logic [DW-1:0] aligned_data;
  logic          aligned_valid, locked, lock_lost, sweep_fail;
  logic [2:0]    slip;

  int errors = 0;
  int checks = 0;

  ldi_word_aligner #(
    .LANES      (LANES),
    .PATTERN    (PAT),
    .LOCK_COUNT (LOCKN),
    .LOSS_COUNT (LOSSN),
    .SETTLE     (SETTLEN)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .clk_lane_word   (clk_lane_word),
    .data_lane_words (data_lane_words),
    .aligned_data    (aligned_data),
    .aligned_valid   (aligned_valid),
    .locked          (locked),
    .slip            (slip),
    .lock_lost       (lock_lost),
    .sweep_fail      (sweep_fail)
  );

  always #5 clock = ~clock;

  // Reference model: the raw words form a serial bit stream per lane; an
  // aligned word is the 7 bits starting "slip" bits into the previous word.
  logic [6:0]    clkq[$];
  logic [DW-1:0] datq[$];
  int            m_state;   // 0 search, 1 verify, 2 locked
  int            m_slip, m_settle, m_mc, m_ec, m_sweep;
  bit            m_locked, m_lost, m_sfail, m_valid;
  logic [DW-1:0] m_aligned;
  int            k_cnt;

  function automatic logic [6:0] clk_win(input int s);
    logic [6:0] r, w;
    int b, pos;
    b = clkq.size() - 2;
    for (int i = 0; i < 7; i++) begin
      pos = s + i;
      w = clkq[b + pos / 7];
      r[6 - i] = w[6 - pos % 7];
    end
    return r;
  endfunction

  function automatic logic [6:0] data_win(input int lane, input int s);
    logic [6:0] r;
    logic [DW-1:0] w;
    int b, pos;
    b = datq.size() - 2;
    for (int i = 0; i < 7; i++) begin
      pos = s + i;
      w = datq[b + pos / 7];
      r[6 - i] = w[7 * lane + 6 - pos % 7];
    end
    return r;
  endfunction

  function automatic logic [6:0] rotr(input logic [6:0] w, input int n);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = w[(i + n) % 7];
    return r;
  endfunction

  function automatic logic [6:0] cword(input int k, input int lane);
    return 7'((k * 3 + lane * 17 + 5) & 127);
  endfunction

  task automatic model_reset();
    clkq.delete(); datq.delete();
    clkq.push_back('0); datq.push_back('0);
    m_state = 0; m_slip = 0; m_settle = 0; m_mc = 0; m_ec = 0; m_sweep = 0;
    m_locked = 0; m_lost = 0; m_sfail = 0; m_valid = 0; m_aligned = '0;
  endtask

  task automatic model_edge(input bit en);
    bit match, adv;
    match = (clk_win(m_slip) == PAT);
    adv = 0;
    for (int l = 0; l < LANES; l++) m_aligned[7*l +: 7] = data_win(l, m_slip);
    m_lost = 0;
    if (!en) begin
      m_state = 0; m_mc = 0; m_ec = 0; m_sweep = 0; m_settle = SETTLEN; m_sfail = 0;
    end else if (m_settle > 0) begin
      m_settle--;
    end else begin
      if (match) m_sweep = 0;
      if (m_state == 0) begin
        if (match) begin m_state = 1; m_mc = 1; end
        else adv = 1;
      end else if (m_state == 1) begin
        if (match) begin
          m_mc++;
          if (m_mc == LOCKN) begin m_state = 2; m_ec = 0; m_sfail = 0; end
        end else begin
          m_state = 0; m_mc = 0; adv = 1;
        end
      end else begin
        if (match) m_ec = 0;
        else begin
          m_ec++;
          if (m_ec == LOSSN) begin
            m_state = 0; m_ec = 0; m_mc = 0; m_settle = SETTLEN; m_lost = 1;
          end
        end
      end
      if (adv) begin
        m_slip = (m_slip + 1) % 7;
        m_settle = SETTLEN;
        if (m_sweep < 255) m_sweep++;
        if (m_sweep >= 7) m_sfail = 1;
      end
    end
    m_locked = (m_state == 2);
    m_valid = m_locked && en;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string ph);
    chk({ph, "_locked"}, 64'(locked), 64'(m_locked));
    chk({ph, "_slip"}, 64'(slip), 64'(m_slip));
    chk({ph, "_lock_lost"}, 64'(lock_lost), 64'(m_lost));
    chk({ph, "_sweep_fail"}, 64'(sweep_fail), 64'(m_sfail));
    chk({ph, "_valid"}, 64'(aligned_valid), 64'(m_valid));
    chk({ph, "_data"}, 64'(aligned_data), 64'(m_aligned));
  endtask

  task automatic step(input logic [6:0] cw, input logic [DW-1:0] dw, input bit en);
    clk_lane_word = cw;
    data_lane_words = dw;
    enable = en;
    clkq.push_back(cw);
    datq.push_back(dw);
    @(posedge clock);
    model_edge(en);
    #1;
    chk_all("cyc");
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'($urandom);
  endfunction

  // Data lanes carry a per-lane counter whose serial stream is offset by 3 bits.
  task automatic cnt_step(input logic [6:0] cw);
    logic [DW-1:0] dw;
    logic [13:0] pair;
    for (int l = 0; l < LANES; l++) begin
      pair = {cword(k_cnt - 1, l), cword(k_cnt, l)};
      dw[7*l +: 7] = pair[9:3];
    end
    step(cw, dw, 1'b1);
    k_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    enable = 1'b0;
    clk_lane_word = '0;
    data_lane_words = '0;
    model_reset();
    @(negedge clock);
    chk_all("rst");
    reset_n = 1'b1;
    k_cnt = 1;
  endtask

  task automatic lock_up(input int shift, input bit use_cnt, output int lat, output bit ok);
    int t3;
    t3 = -1; lat = -1; ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (use_cnt) cnt_step(rotr(PAT, shift));
      else step(rotr(PAT, shift), rnd_data(), 1'b1);
      if (t3 < 0 && slip == 3'(shift)) t3 = i;
      if (locked) begin lat = i - t3; ok = 1; break; end
    end
  endtask

  initial begin
    int lat, kk, adv, early, badseq, anylock, pulses, prev_slip, cnt;
    bit ok, reached;
    logic [DW-1:0] exp;
    logic [6:0] good;

    // 1: clock lane rotated by 3, counter data
    do_reset();
    lock_up(3, 1'b1, lat, ok);
    chk("t1_locked", 64'(ok), 64'd1);
    chk("t1_slip", 64'(slip), 64'd3);
    chk("t1_latency", 64'(lat), 64'(LOCKN + SETTLEN));
    for (int i = 0; i < 5; i++) begin
      kk = k_cnt;
      cnt_step(rotr(PAT, 3));
      for (int l = 0; l < LANES; l++) exp[7*l +: 7] = cword(kk - 1, l);
      chk("t1_data", 64'(aligned_data), 64'(exp));
      chk("t1_valid", 64'(aligned_valid), 64'd1);
    end

    // 2: error tolerance at slip 3 (mask touches only the cur part of the window)
    good = rotr(PAT, 3);
    for (int i = 0; i < 3; i++) step(good ^ 7'h70, rnd_data(), 1'b1);
    for (int i = 0; i < 2; i++) step(good, rnd_data(), 1'b1);
    for (int i = 0; i < 3; i++) step(good ^ 7'h70, rnd_data(), 1'b1);
    step(good, rnd_data(), 1'b1);
    chk("t2_hold", 64'(locked), 64'd1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(good ^ 7'h70, rnd_data(), 1'b1);
      if (lock_lost) pulses++;
    end
    chk("t2_unlocked", 64'(locked), 64'd0);
    chk("t2_slip_kept", 64'(slip), 64'd3);
    for (int i = 0; i < 3; i++) begin
      step(good, rnd_data(), 1'b1);
      if (lock_lost) pulses++;
    end
    chk("t2_pulses", 64'(pulses), 64'd1);

    // 3: dead clock lane sweeps every slip
    do_reset();
    adv = 0; early = 0; badseq = 0; anylock = 0; prev_slip = 0;
    for (int i = 0; i < 40; i++) begin
      step(7'h00, rnd_data(), 1'b1);
      if (slip != 3'(prev_slip)) begin
        adv++;
        if (3'((prev_slip + 1) % 7) != slip) badseq++;
        if (adv == 7) begin
          chk("t3_fail_at7", 64'(sweep_fail), 64'd1);
          chk("t3_wrap", 64'(slip), 64'd0);
        end
        prev_slip = int'(slip);
      end
      if (adv < 7 && sweep_fail) early = 1;
      if (locked) anylock = 1;
    end
    chk("t3_early", 64'(early), 64'd0);
    chk("t3_seq", 64'(badseq), 64'd0);
    chk("t3_advances", 64'(adv), 64'((40 + SETTLEN) / (SETTLEN + 1)));
    chk("t3_nolock", 64'(anylock), 64'd0);

    // 4: VERIFY at slip 5 interrupted at match count 10
    do_reset();
    reached = 0;
    for (int i = 0; i < 80; i++) begin
      if (m_state == 1 && m_mc == 10) begin reached = 1; break; end
      step(rotr(PAT, 5), rnd_data(), 1'b1);
    end
    chk("t4_reached", 64'(reached), 64'd1);
    chk("t4_slip5", 64'(slip), 64'd5);
    step(rotr(PAT, 5) ^ 7'h7C, rnd_data(), 1'b1);
    chk("t4_slip6", 64'(slip), 64'd6);
    chk("t4_unlocked", 64'(locked), 64'd0);

    // 5: enable dropped while locked, then relock
    do_reset();
    lock_up(3, 1'b0, lat, ok);
    chk("t5_locked", 64'(ok), 64'd1);
    step(rotr(PAT, 3), rnd_data(), 1'b0);
    chk("t5_locked_off", 64'(locked), 64'd0);
    chk("t5_valid_off", 64'(aligned_valid), 64'd0);
    chk("t5_no_pulse", 64'(lock_lost), 64'd0);
    chk("t5_slip_held", 64'(slip), 64'd3);
    for (int i = 0; i < 3; i++) step(rotr(PAT, 3), rnd_data(), 1'b0);
    cnt = -1;
    for (int i = 0; i < 60; i++) begin
      step(rotr(PAT, 3), rnd_data(), 1'b1);
      if (locked) begin cnt = i + 1; break; end
    end
    chk("t5_relock_cycles", 64'(cnt), 64'(LOCKN + SETTLEN));
    chk("t5_relock_slip", 64'(slip), 64'd3);

    // 6: asynchronous reset mid-VERIFY
    do_reset();
    reached = 0;
    for (int i = 0; i < 80; i++) begin
      if (m_state == 1 && m_mc == 5) begin reached = 1; break; end
      step(rotr(PAT, 3), rnd_data(), 1'b1);
    end
    chk("t6_reached", 64'(reached), 64'd1);
    chk("t6_pre_slip", 64'(slip), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_slip", 64'(slip), 64'd0);
    chk("t6_data", 64'(aligned_data), 64'd0);
    chk("t6_locked", 64'(locked), 64'd0);
    chk("t6_valid", 64'(aligned_valid), 64'd0);
    chk("t6_lost", 64'(lock_lost), 64'd0);
    chk("t6_sfail", 64'(sweep_fail), 64'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("t6_slip_release", 64'(slip), 64'd0);

    // 7: random rotation, random data
    for (int r = 0; r < 3; r++) begin
      int sh;
      do_reset();
      sh = int'($urandom_range(0, 6));
      lock_up(sh, 1'b0, lat, ok);
      chk("t7_locked", 64'(ok), 64'd1);
      chk("t7_slip", 64'(slip), 64'(sh));
      for (int i = 0; i < 4; i++) step(rotr(PAT, sh), rnd_data(), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldi_word_aligner.md
Name: ldi_word_aligner

Overview:
- Word-alignment controller for LVDS Display Interface receive lanes.
- Takes the raw 7-bit words that the per-lane SDR deserializers have resampled into the pixel-clock domain: one LDI clock lane plus LANES data lanes.
- Finds the bit rotation at which the clock-lane word equals the LDI clock pattern, then applies that same rotation to every data lane.
- Sits between the deserializer bank and the LDI pixel unpacker. Reports lock status to the display-control CSR block.

Parameters:
- LANES, 4, number of data lanes, range 1..8.
- PATTERN, 7'b1100011, expected clock-lane word once aligned, MSB is the earliest bit.
- LOCK_COUNT, 16, consecutive matches needed to declare lock, range 2..255.
- LOSS_COUNT, 4, consecutive mismatches while locked that drop lock, range 1..255.
- SETTLE, 2, compare cycles ignored after every slip change, range 1..15.

Ports:
- clock  in  1  pixel-domain clock, the same clock the deserializers resample on.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  aligner run; low forces SEARCH.
- clk_lane_word  in  7  raw clock-lane word, MSB earliest.
- data_lane_words  in  7*LANES  raw data-lane words; lane k is bits [7k+6:7k].
- aligned_data  out  7*LANES  rotated data-lane words.
- aligned_valid  out  1  high while LOCKED and enable.
- locked  out  1  lock status.
- slip  out  3  current rotation, 0..6.
- lock_lost  out  1  one-cycle pulse on LOCKED->SEARCH due to errors.
- sweep_fail  out  1  sticky; a full 7-slip sweep found no match. Cleared on entering LOCKED or on enable low.

Behaviour:
- Reset values: all outputs 0, slip=0, state SEARCH, counters 0, prev words 0.
- Window:
  - Each lane registers its current word as prev every cycle.
  - W = {prev, cur}, 14 bits, bit 13 earliest.
  - Aligned word = W[13-slip : 7-slip]. slip=0 passes prev unchanged.
- Pipeline:
  - aligned_data is registered.
  - A lane word presented at cycle n appears in aligned_data at cycle n+2 for slip=0.
  - The compare uses the same rotation logic on the clock lane, producing match at stage n+1.
- Settle counter: loaded with SETTLE on every slip change and on entry to SEARCH. While it is nonzero, compares are ignored.
- SEARCH:
  - match -> VERIFY, match_cnt=1.
  - mismatch -> slip = (slip==6) ? 0 : slip+1, reload settle.
  - The 7th consecutive slip advance without any match sets sweep_fail. The sweep counter resets on any match.
- VERIFY:
  - match -> match_cnt++.
  - When match_cnt reaches LOCK_COUNT -> LOCKED, locked=1, sweep_fail=0.
  - mismatch -> SEARCH, slip advances, match_cnt=0.
- LOCKED:
  - match -> err_cnt=0.
  - mismatch -> err_cnt++.
  - When err_cnt reaches LOSS_COUNT -> SEARCH, locked=0, lock_lost=1 for one cycle. slip is kept, so the search resumes at the old slip, and settle is reloaded.
- aligned_valid = locked & enable, registered and aligned with aligned_data.
- enable low:
  - Next cycle: state SEARCH, locked=0, aligned_valid=0, counters cleared, sweep_fail cleared, slip held.
  - No lock_lost pulse.
- Counter widths: 8 bits, saturating. They never wrap.
- Reset asserted mid-lock: all state returns to reset values asynchronously. aligned_data goes to 0.

Decomposition:
- Shared package ldi_pkg:
  - LDI_WORD_W=7 and LDI_CLK_PATTERN=7'b1100011.
  - Enum ldi_align_state_t {SEARCH, VERIFY, LOCKED}.
- Sub-module ldi_lane_rotator: one lane's prev register plus the 14-to-7 slip mux. Instantiated LANES+1 times, the extra instance for the clock lane.

Test Plan:
- Clock lane fed the PATTERN stream rotated by 3 bits, data lanes carrying a counter.
  - Required: slip settles at 3; locked rises after 16 consecutive matches plus settle.
  - Required: aligned_data equals the unrotated counter, with aligned_valid high.
- Locked at slip 3, then 3 corrupted clock words followed by good words.
  - Required: locked stays 1 and err_cnt returns to 0.
  - Then 4 corrupted words in a row: lock_lost pulses once, locked=0, search restarts at slip 3.
- Clock lane held at 7'h00 for 40 cycles.
  - Required: slip cycles 0..6 and wraps to 0; sweep_fail sets after the 7th advance; locked stays 0.
- A match at slip 5 during VERIFY, then a single mismatch at match_cnt=10.
  - Required: state returns to SEARCH, slip=6, match_cnt=0.
- enable dropped while locked.
  - Required: next cycle locked=0, aligned_valid=0, no lock_lost pulse, slip held.
  - On re-enable: relock at the same slip after LOCK_COUNT+SETTLE cycles.
- reset_n asserted asynchronously mid-VERIFY.
  - Required: all outputs 0 immediately, without waiting for a clock edge; slip=0 after release.
